// File: rtl/mem_wr_pipe_pkg.sv
// Shared types for the MEM->WB pipeline stage: state encoding and payload sizing.
package mem_wr_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    function automatic int payload_w(input int data_w, input int rw_w, input int op_w);
        return 2 * data_w + rw_w + op_w + 2;
    endfunction

endpackage

// File: rtl/mem_wr_pipe_if.sv
// MEM-side and WB-side handshake bundle for mem_wr_pipe, plus flush and occupancy.
interface mem_wr_pipe_if #(
    parameter int DATA_W = 32,
    parameter int RW_W   = 5,
    parameter int OP_W   = 6
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] mem_dout;
    logic [DATA_W-1:0] mem_result;
    logic [RW_W-1:0]   mem_rw;
    logic              mem_regWr;
    logic              mem_memtoreg;
    logic [OP_W-1:0]   mem_op;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] wr_dout;
    logic [DATA_W-1:0] wr_result;
    logic [RW_W-1:0]   wr_rw;
    logic              wr_regWr;
    logic              wr_memtoreg;
    logic [OP_W-1:0]   wr_op;
    logic [1:0]        occ;

    modport master (
        output flush, in_valid, mem_dout, mem_result, mem_rw, mem_regWr, mem_memtoreg, mem_op,
        output out_ready,
        input  in_ready, out_valid, wr_dout, wr_result, wr_rw, wr_regWr, wr_memtoreg, wr_op, occ
    );

    modport slave (
        input  flush, in_valid, mem_dout, mem_result, mem_rw, mem_regWr, mem_memtoreg, mem_op,
        input  out_ready,
        output in_ready, out_valid, wr_dout, wr_result, wr_rw, wr_regWr, wr_memtoreg, wr_op, occ
    );
endinterface

// File: rtl/mem_wr_pipe.sv
// MEM->WB stage register with valid/ready, synchronous flush and optional 2-entry skid.
// state | meaning
// EMPTY | no entry held, out_valid low
// ONE   | main slot holds the entry presented on wr_*
// TWO   | main presented, skid holds the next entry, in_ready low (SKID=1 only)
module mem_wr_pipe
    import mem_wr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RW_W   = 5,
    parameter int OP_W   = 6,
    parameter int SKID   = 1
) (
    input  logic clk,
    input  logic rst_n,
    mem_wr_pipe_if.slave bus
);

    localparam int PAYLOAD_W = payload_w(DATA_W, RW_W, OP_W);

    state_e               state_q, state_d;
    logic [PAYLOAD_W-1:0] main_q, main_d;
    logic [PAYLOAD_W-1:0] skid_q, skid_d;
    logic [PAYLOAD_W-1:0] in_pl;
    logic                 in_ready;
    logic                 out_valid;
    logic                 push;
    logic                 pop;
    logic                 main_regwr;

    assign in_pl = {bus.mem_dout, bus.mem_result, bus.mem_rw,
                    bus.mem_regWr, bus.mem_memtoreg, bus.mem_op};

    assign out_valid = (state_q != EMPTY);
    assign push      = bus.in_valid & in_ready & ~bus.flush;
    assign pop       = out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        main_d  = in_pl;
                    end
                end
                ONE: begin
                    // Without a skid slot, push in ONE implies out_ready, so push & !pop cannot occur.
                    if (push && !pop) begin
                        if (SKID != 0) begin
                            state_d = TWO;
                            skid_d  = in_pl;
                        end
                    end else if (push && pop) begin
                        main_d = in_pl;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    if (SKID != 0) begin : g_skid
        logic in_ready_q;
        // Registered so WB back-pressure never reaches MEM combinationally.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) in_ready_q <= 1'b1;
            else        in_ready_q <= (state_d != TWO);
        end
        assign in_ready = in_ready_q;
    end else begin : g_noskid
        assign in_ready = ~out_valid | bus.out_ready;
    end

    assign {bus.wr_dout, bus.wr_result, bus.wr_rw, main_regwr, bus.wr_memtoreg, bus.wr_op} = main_q;

    assign bus.wr_regWr  = main_regwr & out_valid;
    assign bus.out_valid = out_valid;
    assign bus.in_ready  = in_ready;
    assign bus.occ       = state_q;

endmodule

// File: tb/tb_mem_wr_pipe.sv
// Randomised plus directed bench for mem_wr_pipe, SKID=1 and SKID=0 instances side by side.
module tb_mem_wr_pipe;

    typedef struct packed {
        logic [31:0] dout;
        logic [31:0] result;
        logic [4:0]  rw;
        logic        regwr;
        logic        mtr;
        logic [5:0]  op;
    } pl_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_wr_pipe_if #(.DATA_W(32), .RW_W(5), .OP_W(6)) if1 ();
    mem_wr_pipe_if #(.DATA_W(32), .RW_W(5), .OP_W(6)) if0 ();

    mem_wr_pipe #(.DATA_W(32), .RW_W(5), .OP_W(6), .SKID(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));
    mem_wr_pipe #(.DATA_W(32), .RW_W(5), .OP_W(6), .SKID(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));

    int  vectors = 0;
    int  errs    = 0;
    pl_t q1[$];
    pl_t q0[$];
    pl_t cur;
    logic rdy1, rdy0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic pl_t mk(input logic [31:0] res, input logic regwr);
        pl_t p;
        p        = '0;
        p.result = res;
        p.dout   = ~res;
        p.rw     = res[4:0];
        p.regwr  = regwr;
        p.mtr    = res[0];
        p.op     = res[10:5];
        return p;
    endfunction

    task automatic drive(input logic v, input pl_t p, input logic ordy, input logic fl);
        if1.in_valid = v;      if0.in_valid = v;
        if1.mem_dout = p.dout; if0.mem_dout = p.dout;
        if1.mem_result = p.result; if0.mem_result = p.result;
        if1.mem_rw = p.rw;     if0.mem_rw = p.rw;
        if1.mem_regWr = p.regwr; if0.mem_regWr = p.regwr;
        if1.mem_memtoreg = p.mtr; if0.mem_memtoreg = p.mtr;
        if1.mem_op = p.op;     if0.mem_op = p.op;
        if1.out_ready = ordy;  if0.out_ready = ordy;
        if1.flush = fl;        if0.flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: a FIFO of capacity 2 (skid) or 1 (plain), emptied by flush.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1.delete();
            q0.delete();
        end else begin
            cur.dout   = if1.mem_dout;
            cur.result = if1.mem_result;
            cur.rw     = if1.mem_rw;
            cur.regwr  = if1.mem_regWr;
            cur.mtr    = if1.mem_memtoreg;
            cur.op     = if1.mem_op;
            rdy1 = (q1.size() < 2);
            rdy0 = (q0.size() == 0) || if1.out_ready;
            if (if1.flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (q1.size() > 0 && if1.out_ready) void'(q1.pop_front());
                if (if1.in_valid && rdy1) q1.push_back(cur);
                if (q0.size() > 0 && if1.out_ready) void'(q0.pop_front());
                if (if1.in_valid && rdy0) q0.push_back(cur);
            end
        end
    end

    task automatic cmp(input string tag, input int n, input pl_t head, input logic exp_ir,
                       input logic ov, input logic [1:0] occ, input logic ir,
                       input pl_t act, input logic act_regwr);
        pl_t a;
        a = act;
        a.regwr = act_regwr;
        chk({tag, "_out_valid"}, 80'(ov), 80'(n > 0));
        chk({tag, "_occ"}, 80'(occ), 80'(n));
        chk({tag, "_in_ready"}, 80'(ir), 80'(exp_ir));
        if (n > 0) chk({tag, "_payload"}, 80'(a), 80'(head));
        else       chk({tag, "_regwr_bubble"}, 80'(act_regwr), 80'(0));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            pl_t a1, a0, h1, h0;
            a1 = '{if1.wr_dout, if1.wr_result, if1.wr_rw, 1'b0, if1.wr_memtoreg, if1.wr_op};
            a0 = '{if0.wr_dout, if0.wr_result, if0.wr_rw, 1'b0, if0.wr_memtoreg, if0.wr_op};
            h1 = (q1.size() > 0) ? q1[0] : '0;
            h0 = (q0.size() > 0) ? q0[0] : '0;
            cmp("skid1", q1.size(), h1, q1.size() < 2,
                if1.out_valid, if1.occ, if1.in_ready, a1, if1.wr_regWr);
            cmp("skid0", q0.size(), h0, (q0.size() == 0) || if1.out_ready,
                if0.out_valid, if0.occ, if0.in_ready, a0, if0.wr_regWr);
        end
    end

    initial begin
        logic [95:0] r;
        pl_t p;

        // Reset with an entry offered
        drive(1'b1, mk(32'hDEAD, 1'b1), 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_out_valid", 80'(if1.out_valid), 80'(0));
        chk("rst_occ", 80'(if1.occ), 80'(0));
        chk("rst_in_ready", 80'(if1.in_ready), 80'(1));
        chk("rst_wr_result", 80'(if1.wr_result), 80'(0));
        chk("rst_wr_dout", 80'(if1.wr_dout), 80'(0));
        chk("rst_wr_misc", 80'({if1.wr_rw, if1.wr_regWr, if1.wr_memtoreg, if1.wr_op}), 80'(0));
        chk("rst0_in_ready", 80'(if0.in_ready), 80'(1));
        #2 rst_n = 1'b1;
        step();
        drive(1'b0, mk(32'h0, 1'b0), 1'b0, 1'b0);
        @(negedge clk);
        chk("first_push_valid", 80'(if1.out_valid), 80'(1));
        chk("first_push_result", 80'(if1.wr_result), 80'(32'hDEAD));
        chk("first_push_result0", 80'(if0.wr_result), 80'(32'hDEAD));
        step();
        drive(1'b0, mk(32'h0, 1'b0), 1'b1, 1'b0);
        step();

        // Streaming 1..4
        drive(1'b1, mk(32'd1, 1'b1), 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k < 4) drive(1'b1, mk(32'(k + 1), 1'b1), 1'b1, 1'b0);
            else       drive(1'b0, mk(32'h0, 1'b0), 1'b1, 1'b0);
            @(negedge clk);
            chk("stream_result", 80'(if1.wr_result), 80'(k));
            chk("stream_occ", 80'(if1.occ), 80'(1));
            chk("stream_in_ready", 80'(if1.in_ready), 80'(1));
            chk("stream_result0", 80'(if0.wr_result), 80'(k));
        end

        // Back-pressure into the skid slot
        step();
        drive(1'b1, mk(32'd5, 1'b0), 1'b0, 1'b0);
        step();
        drive(1'b1, mk(32'd6, 1'b0), 1'b0, 1'b0);
        step();
        drive(1'b0, mk(32'h0, 1'b0), 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_occ", 80'(if1.occ), 80'(2));
        chk("bp_in_ready", 80'(if1.in_ready), 80'(0));
        chk("bp_hold_result", 80'(if1.wr_result), 80'(5));
        chk("bp0_in_ready", 80'(if0.in_ready), 80'(0));
        step();
        drive(1'b1, mk(32'd7, 1'b0), 1'b1, 1'b0);
        @(negedge clk);
        chk("bp0_comb_ready", 80'(if0.in_ready), 80'(1));
        chk("bp_still_5", 80'(if1.wr_result), 80'(5));
        step();
        drive(1'b0, mk(32'h0, 1'b0), 1'b1, 1'b0);
        @(negedge clk);
        chk("bp_second", 80'(if1.wr_result), 80'(6));
        chk("bp0_next", 80'(if0.wr_result), 80'(7));
        step();
        @(negedge clk);
        chk("bp_drained", 80'(if1.occ), 80'(0));

        // Flush while full, with an entry offered in the flush cycle
        step();
        drive(1'b1, mk(32'd8, 1'b1), 1'b0, 1'b0);
        step();
        drive(1'b1, mk(32'd9, 1'b1), 1'b0, 1'b0);
        step();
        drive(1'b1, mk(32'd10, 1'b1), 1'b0, 1'b1);
        @(negedge clk);
        chk("pre_flush_occ", 80'(if1.occ), 80'(2));
        chk("pre_flush_regwr", 80'(if1.wr_regWr), 80'(1));
        step();
        drive(1'b0, mk(32'h0, 1'b0), 1'b1, 1'b0);
        @(negedge clk);
        chk("flush_occ", 80'(if1.occ), 80'(0));
        chk("flush_valid", 80'(if1.out_valid), 80'(0));
        chk("flush_regwr", 80'(if1.wr_regWr), 80'(0));
        chk("flush_in_ready", 80'(if1.in_ready), 80'(1));
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            chk("flush_dropped", 80'(if1.out_valid), 80'(0));
        end

        // Asynchronous reset while full
        step();
        drive(1'b1, mk(32'd11, 1'b1), 1'b0, 1'b0);
        step();
        drive(1'b1, mk(32'd12, 1'b1), 1'b0, 1'b0);
        step();
        drive(1'b0, mk(32'h0, 1'b0), 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_areset_occ", 80'(if1.occ), 80'(2));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("areset_valid", 80'(if1.out_valid), 80'(0));
        chk("areset_occ", 80'(if1.occ), 80'(0));
        chk("areset_regwr", 80'(if1.wr_regWr), 80'(0));
        chk("areset_valid0", 80'(if0.out_valid), 80'(0));
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Random traffic against the reference queues
        for (int i = 0; i < 600; i++) begin
            r = {$urandom, $urandom, $urandom};
            p = r[75:0];
            step();
            drive($urandom_range(0, 3) != 0, p,
                  (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0),
                  $urandom_range(0, 24) == 0);
        end
        step();
        drive(1'b0, mk(32'h0, 1'b0), 1'b1, 1'b0);
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
